rv64m_div_unit: RTL and testbench
=================================

// Module: rv64m_div_unit
// PURPOSE
//  Iterative RV64M divide/remainder unit for div/divu/rem/remu and the W forms.
//  Sits beside the execute stage: takes decoded operands and rd, and hands the
//  result plus rd to the gpr writeback path. Radix-2 restoring, 1 quotient bit/cycle.
// PARAMETERS
//  XLEN   64  operand/result width
//  RD_W   5   destination register index width
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     asynchronous, active-high
//  flush        in   1     abort in-flight op (sync)
//  in_valid     in   1     request valid
//  in_ready     out  1     unit can accept
//  in_op        in   2     0=div 1=divu 2=rem 3=remu
//  in_word      in   1     1 = W variant (32-bit)
//  in_rs1_val   in   XLEN  dividend
//  in_rs2_val   in   XLEN  divisor
//  in_rd        in   RD_W  destination register
//  out_valid    out  1     result valid
//  out_ready    in   1     writeback accepts
//  out_rd       out  RD_W  destination register
//  out_result   out  XLEN  quotient or remainder
//  busy         out  1     state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_rd=0, out_result=0.
//  - FSM: IDLE -(in_valid&in_ready)-> PREP -> CALC (N cycles) -> FIX -> DONE
//    -(out_ready)-> IDLE. N=64, or 32 if in_word.
//  - in_ready = (state==IDLE) & ~flush. Operands, op, word and rd are latched on accept.
//  - PREP: W ops take bits [31:0] only. Signed ops (div/rem) use magnitudes;
//    latch sign_q = sa^sb and sign_r = sa.
//  - CALC: shift {rem,quo} left 1; trial subtract divisor; set quo bit if no borrow.
//  - FIX: negate quotient if sign_q and divisor!=0; negate remainder if sign_r.
//    Select quo or rem by op. W ops sign-extend bit 31 to 64, including divuw/remuw.
//  - Latency: accept at edge k, out_valid=1 from edge k+N+2 (66 or 34 cycles).
//  - Spec results, reached without special-case logic:
//    div by zero -> quotient all ones, remainder = dividend;
//    signed overflow (most-neg / -1) -> quotient = dividend, remainder 0.
//  - DONE: out_valid, out_rd and out_result stay stable until out_ready=1.
//    No new accept in the same cycle (IDLE only).
//  - flush: any state -> IDLE on next edge, out_valid=0, result dropped.
//    flush beats a same-cycle in_valid (in_ready=0).
//  - reset mid-op: immediate return to reset values, no output.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: PREP detects divisor==0 or signed overflow and
//    goes PREP->FIX, skipping CALC. FIX forces the spec results above;
//    out_valid from edge k+2.
//  Not defined: every op takes the full N+2 latency. Results are identical
//    in both builds.
// TESTING
//  1 div 100/7 -> 14; rem -> 2; out_valid exactly 66 cycles after accept.
//  2 div -7/2 -> -3; rem -7/2 -> -1; remu 0xFFFF_FFFF_FFFF_FFF9/2 -> 1.
//  3 div 5/0 -> 0xFFFF_FFFF_FFFF_FFFF; rem 5/0 -> 5.
//    Latency 66 without DIV_EARLY_OUT_EN, 2 with it.
//  4 div 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; rem -> 0.
//    divw 0x8000_0000/-1 -> 0xFFFF_FFFF_8000_0000.
//  5 divuw 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF, 34-cycle latency.
//    Hold out_ready=0 10 cycles -> out_* stable, in_ready=0.
//  6 flush at CALC cycle 20 -> IDLE next edge, no out_valid.
//    Then div 9/3 -> 3. Reset mid-CALC -> all outputs at reset values.

Source files
------------

// File: rtl/rv64m_div_unit.sv
// Iterative RV64M divide/remainder unit (div/divu/rem/remu + W forms), radix-2 restoring.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow bypass the iteration loop.
module rv64m_div_unit #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [RD_W-1:0] in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RD_W-1:0] out_rd,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, is_rem, sa, sb, no_borrow;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quo_fix, rem_fix, sel, fix_result;

  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];

  // W forms operate on the low half, extended according to signedness.
  assign a_ext = word_q ? {{HALF{is_signed & a_q[HALF-1]}}, a_q[HALF-1:0]} : a_q;
  assign b_ext = word_q ? {{HALF{is_signed & b_q[HALF-1]}}, b_q[HALF-1:0]} : b_q;
  assign sa    = is_signed & a_ext[XLEN-1];
  assign sb    = is_signed & b_ext[XLEN-1];
  assign mag_a = sa ? -a_ext : a_ext;
  assign mag_b = sb ? -b_ext : b_ext;

`ifdef DIV_EARLY_OUT_EN
  logic            div_zero, ovf;
  logic [XLEN-1:0] min_val;
  assign min_val  = word_q ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = (b_ext == '0);
  assign ovf      = is_signed & (a_ext == min_val) & (b_ext == '1);
`endif

  // Partial remainder never exceeds 2*divisor-1, so one extra bit covers the trial.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign no_borrow = ~trial[XLEN];

  assign quo_fix    = (neg_quo_q && (dvs_q != '0)) ? -quo_q : quo_q;
  assign rem_fix    = neg_rem_q ? -rem_q : rem_q;
  assign sel        = is_rem ? rem_fix : quo_fix;
  assign fix_result = word_q ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;

  assign in_ready   = (state_q == S_IDLE) & ~flush;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign out_rd     = rd_q;
  assign out_result = result_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = in_op;
          word_d  = in_word;
          a_d     = in_rs1_val;
          b_d     = in_rs2_val;
          rd_d    = in_rd;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // W dividends are pre-aligned to the top so the same shifter serves both widths.
        quo_d     = word_q ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
        rem_d     = '0;
        dvs_d     = mag_b;
        neg_quo_d = sa ^ sb;
        neg_rem_d = sa;
        cnt_d     = word_q ? CW'(HALF - 1) : CW'(XLEN - 1);
        state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
        if (div_zero) begin
          quo_d   = '1;
          rem_d   = mag_a;
          state_d = S_FIX;
        end else if (ovf) begin
          quo_d   = mag_a;
          rem_d   = '0;
          state_d = S_FIX;
        end
`endif
      end
      S_CALC: begin
        quo_d = {quo_q[XLEN-2:0], no_borrow};
        rem_d = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        result_d = fix_result;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      word_q    <= word_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_rv64m_div_unit.sv
// Self-checking bench for rv64m_div_unit: arithmetic reference model plus scoreboard monitor.
// Latency expectations follow DIV_EARLY_OUT_EN when it is defined for the build.
module tb_rv64m_div_unit;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_word, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [63:0] in_rs1_val, in_rs2_val, out_result;
  logic [4:0]  in_rd, out_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  bit   seen_first = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv64m_div_unit dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with the RISC-V special cases spelled out.
  function automatic logic [63:0] model(input logic [1:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0]     r32;
    logic [63:0]     r;
    int              sa32, sb32;
    int unsigned     ua32, ub32;
    longint          sa64, sb64;
    longint unsigned ua64, ub64;
    bit              ovf;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    sa64 = a; sb64 = b; ua64 = a; ub64 = b;
    r32 = '0;
    r = '0;
    if (w) begin
      ovf = (sa32 == int'(32'h8000_0000)) && (sb32 == -1);
      case (op)
        2'd0: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : ovf ? a[31:0] : 32'(sa32 / sb32);
        2'd1: r32 = (ub32 == 0) ? 32'hFFFF_FFFF : 32'(ua32 / ub32);
        2'd2: r32 = (ub32 == 0) ? a[31:0] : ovf ? 32'h0 : 32'(sa32 % sb32);
        default: r32 = (ub32 == 0) ? a[31:0] : 32'(ua32 % ub32);
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      ovf = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
      case (op)
        2'd0: r = (ub64 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'(sa64 / sb64);
        2'd1: r = (ub64 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(ua64 / ub64);
        2'd2: r = (ub64 == 0) ? a : ovf ? 64'h0 : 64'(sa64 % sb64);
        default: r = (ub64 == 0) ? a : 64'(ua64 % ub64);
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic zero, ovf;
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (zero || ovf) return 2;
`endif
    return w ? 34 : 66;
  endfunction

  // Single compare process: every negedge, outputs are checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0) begin
        check("busy_inflight", {63'd0, busy}, 64'd1);
        if (out_valid) begin
          check("out_result", out_result, sb[0].res);
          check("out_rd", {59'd0, out_rd}, {59'd0, sb[0].rd});
          check("in_ready_while_done", {63'd0, in_ready}, 64'd0);
          if (!seen_first) begin
            seen_first = 1'b1;
            check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          end
          if (out_ready) begin
            void'(sb.pop_front());
            seen_first = 1'b0;
          end
        end
      end else if (out_valid) begin
        check("spurious_out_valid", {63'd0, out_valid}, 64'd0);
      end
    end
  end

  task automatic do_op(input string name, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                       input logic [63:0] lit, input int hold);
    exp_t e;
    int   t;
    e.res = model(op, w, a, b);
    check({name, "_model"}, e.res, lit);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_word = w; in_rs1_val = a; in_rs2_val = b; in_rd = rd;
    out_ready = (hold == 0);
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check({name, "_accept_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e.rd = rd;
    e.acc = cyc;
    e.lat = model_lat(op, w, a, b);
    sb.push_back(e);
    $display("txn %s op=%0d w=%0d a=%h b=%h rd=%0d expect=%h", name, op, w, a, b, rd, e.res);
    if (hold > 0) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk);
        #1;
        t++;
      end
      repeat (hold) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check({name, "_result_timeout"}, 64'd0, 64'd1);
      sb.delete();
      seen_first = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_word = 1'b0;
    in_rs1_val = '0; in_rs2_val = '0; in_rd = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check("rst_out_result", out_result, 64'd0);
    reset = 1'b0;

    do_op("div_100_7",  2'd0, 1'b0, 64'd100, 64'd7, 5'd1, 64'd14, 0);
    do_op("rem_100_7",  2'd2, 1'b0, 64'd100, 64'd7, 5'd2, 64'd2, 0);
    do_op("div_m7_2",   2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op("rem_m7_2",   2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("remu_big_2", 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5, 64'd1, 0);
    do_op("div_5_0",    2'd0, 1'b0, 64'd5, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_op("rem_5_0",    2'd2, 1'b0, 64'd5, 64'd0, 5'd7, 64'd5, 0);
    do_op("div_ovf",    2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
          64'h8000_0000_0000_0000, 0);
    do_op("rem_ovf",    2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0, 0);
    do_op("divw_ovf",   2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10,
          64'hFFFF_FFFF_8000_0000, 0);
    do_op("divuw_hold", 2'd1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 10);
    do_op("divu_1000_3", 2'd1, 1'b0, 64'd1000, 64'd3, 5'd12, 64'd333, 0);
    do_op("divw_m100_7", 2'd0, 1'b1, 64'h5555_0000_FFFF_FF9C, 64'h0000_0001_0000_0007, 5'd13,
          64'hFFFF_FFFF_FFFF_FFF2, 0);
    do_op("remuw_100_7", 2'd3, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'hAAAA_0000_0000_0007, 5'd14, 64'd2, 0);

    // Flush in the middle of the iteration loop, with a competing request in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_word = 1'b0; in_rs1_val = 64'd1000; in_rs2_val = 64'd7;
    in_rd = 5'd20; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("txn flush_victim accepted rd=20 (no result expected)");
    repeat (21) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_rs1_val = 64'd50; in_rs2_val = 64'd5;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(posedge clk);
    #1;
    check("post_flush_busy", {63'd0, busy}, 64'd0);

    do_op("div_9_3", 2'd0, 1'b0, 64'd9, 64'd3, 5'd21, 64'd3, 0);

    // Asynchronous reset mid-iteration.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_word = 1'b0; in_rs1_val = 64'd12345; in_rs2_val = 64'd10;
    in_rd = 5'd22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("txn reset_victim accepted rd=22 (no result expected)");
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_out_rd", {59'd0, out_rd}, 64'd0);
    check("midrst_out_result", out_result, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    do_op("remw_m7_2", 2'd2, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 5'd23, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
